mtpsa_user_wrr_arbiter: RTL and testbench
=========================================

// Module: mtpsa_user_wrr_arbiter
// PURPOSE
//   Packet-granular weighted round-robin arbiter sharing the single suIngress SDNet pipeline
//   between NUM_QUEUES per-user AXIS input queues. Sits directly upstream of the suIngress
//   wrapper. Grants whole packets only, never interleaves beats. Optionally stamps the
//   granted queue index into tuser user_id [39:32].
// PARAMETERS
//   NUM_QUEUES     4    number of requesting user queues (2..8)
//   DATA_WIDTH     256  AXIS tdata width; tkeep width = DATA_WIDTH/8
//   TUSER_WIDTH    128  AXIS tuser width (SUME format, user_id at [39:32])
//   WEIGHT_WIDTH   4    width of each per-queue weight
//   STAMP_USER_ID  1    1: output tuser[39:32] = granted queue index; 0: pass through
// PORTS
//   axis_aclk      in   1                      single clock for all logic
//   axis_resetn    in   1                      asynchronous, active-low reset
//   s_axis_tdata   in   NUM_QUEUES*DATA_WIDTH  queue q at slice [q*DATA_WIDTH +: DATA_WIDTH]
//   s_axis_tkeep   in   NUM_QUEUES*DATA_WIDTH/8  per-queue tkeep, same slicing
//   s_axis_tuser   in   NUM_QUEUES*TUSER_WIDTH per-queue tuser, same slicing
//   s_axis_tvalid  in   NUM_QUEUES             per-queue valid
//   s_axis_tready  out  NUM_QUEUES             per-queue ready
//   s_axis_tlast   in   NUM_QUEUES             per-queue last
//   m_axis_tdata   out  DATA_WIDTH             to suIngress packet input
//   m_axis_tkeep   out  DATA_WIDTH/8
//   m_axis_tuser   out  TUSER_WIDTH
//   m_axis_tvalid  out  1
//   m_axis_tready  in   1
//   m_axis_tlast   out  1
//   cfg_weights    in   NUM_QUEUES*WEIGHT_WIDTH  max consecutive packets per grant; 0 treated as 1
//   grant_valid    out  1                      high while a packet transfer is owned
//   grant_id       out  3                      index of owning queue
//   pkt_count      out  32                     packets forwarded since reset (wraps)
// BEHAVIOUR
//   - Reset (async assert, sync deassert): state=IDLE, grant_valid=0, grant_id=0, burst_cnt=0,
//     last_q=NUM_QUEUES-1, pkt_count=0; all s_axis_tready=0, m_axis_tvalid=0.
//   - FSM IDLE -> XFER -> IDLE.
//     IDLE: if any s_axis_tvalid, register winner into grant_id, set grant_valid, go XFER.
//       No request: stay IDLE, nothing changes.
//     XFER: combinational pass-through of queue grant_id.
//       m_axis_t{data,keep,user,last,valid} = slice[grant_id]; s_axis_tready[grant_id]=m_axis_tready.
//       All other s_axis_tready=0.
//       On beat with tvalid&tready&tlast: pkt_count++, grant_valid<=0, go IDLE.
//   - Latency: first beat of a packet presented 1 cycle after IDLE sees valid.
//     Exactly one bubble cycle between packets (also between packets of the same queue).
//   - Winner selection in IDLE, weight w = max(cfg_weights[q],1) sampled at decision time.
//     If s_axis_tvalid[last_q] and burst_cnt < w(last_q): re-grant last_q, burst_cnt++.
//     Else: first valid queue scanning last_q+1, last_q+2, ... modulo NUM_QUEUES.
//       That queue wins; burst_cnt=1; last_q=winner.
//       If it wraps back to last_q, that still counts as a new grant (burst_cnt=1).
//   - Queue dropping tvalid mid-packet: grant held, m_axis_tvalid follows it, no timeout.
//   - cfg_weights change mid-packet: no effect until next IDLE decision.
//   - STAMP_USER_ID=1: m_axis_tuser[39:32] = {5'b0, grant_id}; all other tuser bits pass unchanged.
//   - Reset mid-packet: transfer aborted immediately, outputs go to reset values.
//     No tlast synthesised downstream; the suIngress side is reset by the same signal.
//   - pkt_count wraps 0xFFFFFFFF -> 0.
// TESTING
//   1 Reset: hold axis_resetn=0 with all tvalid=1 -> tready=0, m_axis_tvalid=0, pkt_count=0;
//     first beat appears 1 cycle after release +1 IDLE cycle.
//   2 Equal weights=1, queues 0-3 each 3-beat packets continuously -> grant order 0,1,2,3,0...;
//     1 bubble between packets; pkt_count=8 after 8 packets.
//   3 weights {q0=3,q1=1}, both backlogged -> order 0,0,0,1,0,0,0,1.
//     weight 0 on q2 behaves as weight 1.
//   4 Backpressure: m_axis_tready toggling 1010 during q1 packet -> no beat lost or duplicated,
//     other tready stay 0, tlast aligned.
//   5 Only q2 valid, weight 2, 5 packets -> all granted to q2 with grant_id=2, no stall beyond bubble.
//     STAMP_USER_ID=1 gives tuser[39:32]=0x02.
//   6 Assert reset on beat 2 of a 4-beat packet -> outputs to reset values next edge.
//     After release, arbitration restarts from queue 0.

Source files
------------

// File: rtl/mtpsa_user_wrr_arbiter.sv
// Packet-granular weighted round-robin arbiter feeding the shared suIngress pipeline.
// Whole packets are granted to one user queue at a time; the queue index can be stamped into tuser.
module mtpsa_user_wrr_arbiter #(
  parameter int NUM_QUEUES    = 4,
  parameter int DATA_WIDTH    = 256,
  parameter int TUSER_WIDTH   = 128,
  parameter int WEIGHT_WIDTH  = 4,
  parameter int STAMP_USER_ID = 1
) (
  input  logic                               axis_aclk,
  input  logic                               axis_resetn,
  input  logic [NUM_QUEUES*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [NUM_QUEUES*DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [NUM_QUEUES*TUSER_WIDTH-1:0]  s_axis_tuser,
  input  logic [NUM_QUEUES-1:0]              s_axis_tvalid,
  output logic [NUM_QUEUES-1:0]              s_axis_tready,
  input  logic [NUM_QUEUES-1:0]              s_axis_tlast,
  output logic [DATA_WIDTH-1:0]              m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]            m_axis_tkeep,
  output logic [TUSER_WIDTH-1:0]             m_axis_tuser,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic                               m_axis_tlast,
  input  logic [NUM_QUEUES*WEIGHT_WIDTH-1:0] cfg_weights,
  output logic                               grant_valid,
  output logic [2:0]                         grant_id,
  output logic [31:0]                        pkt_count
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic                    r_grant_valid;
  logic [2:0]              r_grant_id;
  logic [2:0]              r_last_q;
  logic [WEIGHT_WIDTH-1:0] r_burst_cnt;
  logic [31:0]             r_pkt_count;

  logic [DATA_WIDTH-1:0]   w_sel_data;
  logic [KEEP_WIDTH-1:0]   w_sel_keep;
  logic [TUSER_WIDTH-1:0]  w_sel_user;
  logic                    w_sel_valid;
  logic                    w_sel_last;
  logic                    w_last_valid;
  logic [WEIGHT_WIDTH-1:0] w_last_weight;
  logic                    w_regrant;
  logic                    w_rr_found;
  logic [2:0]              w_rr_idx;
  logic                    w_pkt_done;

  function automatic int wrapIdx(input int i);
    return (i >= NUM_QUEUES) ? i - NUM_QUEUES : i;
  endfunction

  always_comb begin
    w_sel_data    = '0;
    w_sel_keep    = '0;
    w_sel_user    = '0;
    w_sel_valid   = 1'b0;
    w_sel_last    = 1'b0;
    w_last_valid  = 1'b0;
    w_last_weight = '0;
    for (int q = 0; q < NUM_QUEUES; q++) begin
      if (3'(q) == r_grant_id) begin
        w_sel_data  = s_axis_tdata[q*DATA_WIDTH +: DATA_WIDTH];
        w_sel_keep  = s_axis_tkeep[q*KEEP_WIDTH +: KEEP_WIDTH];
        w_sel_user  = s_axis_tuser[q*TUSER_WIDTH +: TUSER_WIDTH];
        w_sel_valid = s_axis_tvalid[q];
        w_sel_last  = s_axis_tlast[q];
      end
      if (3'(q) == r_last_q) begin
        w_last_valid  = s_axis_tvalid[q];
        w_last_weight = cfg_weights[q*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      end
    end
    // A zero weight still earns one packet per turn.
    if (w_last_weight == '0) begin
      w_last_weight = WEIGHT_WIDTH'(1);
    end
  end

  // Scan starts just after the previous winner and may wrap back onto it.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    for (int k = 1; k <= NUM_QUEUES; k++) begin
      for (int q = 0; q < NUM_QUEUES; q++) begin
        if (!w_rr_found && s_axis_tvalid[q] && (wrapIdx(int'(r_last_q) + k) == q)) begin
          w_rr_found = 1'b1;
          w_rr_idx   = 3'(q);
        end
      end
    end
  end

  assign w_regrant  = w_last_valid && (r_burst_cnt < w_last_weight);
  assign w_pkt_done = (r_state == ST_XFER) && w_sel_valid && m_axis_tready && w_sel_last;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_rr_found) w_state_next = ST_XFER;
      ST_XFER: if (w_pkt_done) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      r_grant_valid <= 1'b0;
      r_grant_id    <= '0;
      r_last_q      <= 3'(NUM_QUEUES - 1);
      r_burst_cnt   <= '0;
      r_pkt_count   <= '0;
    end else begin
      if (r_state == ST_IDLE && w_rr_found) begin
        r_grant_valid <= 1'b1;
        if (w_regrant) begin
          r_grant_id  <= r_last_q;
          r_burst_cnt <= r_burst_cnt + WEIGHT_WIDTH'(1);
        end else begin
          r_grant_id  <= w_rr_idx;
          r_last_q    <= w_rr_idx;
          r_burst_cnt <= WEIGHT_WIDTH'(1);
        end
      end
      if (w_pkt_done) begin
        r_grant_valid <= 1'b0;
        r_pkt_count   <= r_pkt_count + 32'd1;
      end
    end
  end

  always_comb begin
    m_axis_tuser = w_sel_user;
    if (STAMP_USER_ID != 0) begin
      m_axis_tuser[39:32] = {5'b0, r_grant_id};
    end
  end

  always_comb begin
    s_axis_tready = '0;
    for (int q = 0; q < NUM_QUEUES; q++) begin
      if (r_state == ST_XFER && 3'(q) == r_grant_id) begin
        s_axis_tready[q] = m_axis_tready;
      end
    end
  end

  assign m_axis_tdata  = w_sel_data;
  assign m_axis_tkeep  = w_sel_keep;
  assign m_axis_tlast  = w_sel_last;
  assign m_axis_tvalid = (r_state == ST_XFER) && w_sel_valid;
  assign grant_valid   = r_grant_valid;
  assign grant_id      = r_grant_id;
  assign pkt_count     = r_pkt_count;

endmodule

// File: tb/tb_mtpsa_user_wrr_arbiter.sv
// Directed bench for mtpsa_user_wrr_arbiter: per-queue packet sources, an output
// monitor checking every beat against the hand-written grant order, and phase checks.
module tb_mtpsa_user_wrr_arbiter;

  localparam int NQ = 4;
  localparam int DW = 256;
  localparam int KW = DW / 8;
  localparam int UW = 128;
  localparam int WW = 4;

  logic             axis_aclk;
  logic             axis_resetn;
  logic [NQ*DW-1:0] s_axis_tdata;
  logic [NQ*KW-1:0] s_axis_tkeep;
  logic [NQ*UW-1:0] s_axis_tuser;
  logic [NQ-1:0]    s_axis_tvalid;
  logic [NQ-1:0]    s_axis_tready;
  logic [NQ-1:0]    s_axis_tlast;
  logic [DW-1:0]    m_axis_tdata;
  logic [KW-1:0]    m_axis_tkeep;
  logic [UW-1:0]    m_axis_tuser;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
  logic             m_axis_tlast;
  logic [NQ*WW-1:0] cfg_weights;
  logic             grant_valid;
  logic [2:0]       grant_id;
  logic [31:0]      pkt_count;

  int checkCount = 0;
  int errorCount = 0;

  logic [NQ-1:0] srcEn;
  logic [NQ-1:0] fired;
  int srcLeft[NQ];
  int srcLen[NQ];
  int srcBeat[NQ];
  int srcSeq[NQ];
  int expSeq[NQ];
  int expOrder[$];
  int pktIdx;
  int beatIdx;
  int lastTlastCycle;
  int cyc = 0;
  bit gapCheck;
  bit readyToggle;

  mtpsa_user_wrr_arbiter #(
    .NUM_QUEUES(NQ), .DATA_WIDTH(DW), .TUSER_WIDTH(UW), .WEIGHT_WIDTH(WW), .STAMP_USER_ID(1)
  ) dut (
    .axis_aclk(axis_aclk), .axis_resetn(axis_resetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .cfg_weights(cfg_weights), .grant_valid(grant_valid), .grant_id(grant_id), .pkt_count(pkt_count)
  );

  initial begin
    axis_aclk = 1'b0;
    forever #5 axis_aclk = ~axis_aclk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [DW-1:0] mkData(input int q, input int seq, input int beat);
    return {8{8'(q), 8'(seq), 8'(beat), 8'hD0}};
  endfunction

  function automatic logic [UW-1:0] mkUser(input int q, input int seq, input logic [7:0] uid);
    return {{11{8'h5A}}, uid, 8'h00, 8'(q), 16'(seq)};
  endfunction

  function automatic logic [KW-1:0] mkKeep(input bit isLast);
    return isLast ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Advances each source on a completed handshake and re-drives every input for the next cycle.
  task automatic applyStimulus();
    for (int q = 0; q < NQ; q++) begin
      if (axis_resetn && fired[q]) begin
        if (srcBeat[q] == srcLen[q] - 1) begin
          srcBeat[q] = 0;
          srcSeq[q]++;
          srcLeft[q]--;
        end else begin
          srcBeat[q]++;
        end
      end
      fired[q] = 1'b0;
      s_axis_tvalid[q]             = srcEn[q] && (srcLeft[q] > 0);
      s_axis_tdata[q*DW +: DW]     = mkData(q, srcSeq[q], srcBeat[q]);
      s_axis_tkeep[q*KW +: KW]     = mkKeep(srcBeat[q] == srcLen[q] - 1);
      s_axis_tuser[q*UW +: UW]     = mkUser(q, srcSeq[q], 8'hA5);
      s_axis_tlast[q]              = (srcBeat[q] == srcLen[q] - 1);
    end
    m_axis_tready = readyToggle ? ~m_axis_tready : 1'b1;
  endtask

  task automatic observeOutput();
    int q;
    bit isLast;
    if (!axis_resetn) return;
    if (!m_axis_tvalid) begin
      checkOutput("idle_tready", s_axis_tready, 0);
      return;
    end
    if (pktIdx >= expOrder.size()) begin
      checkOutput("extra_packet", pktIdx, expOrder.size());
      return;
    end
    q = expOrder[pktIdx];
    isLast = (beatIdx == srcLen[q] - 1);
    checkOutput("grant_id", grant_id, q);
    checkOutput("grant_valid", grant_valid, 1);
    checkOutput("tready_route", s_axis_tready, m_axis_tready ? (4'b1 << q) : 4'b0);
    if (m_axis_tready) begin
      if (beatIdx == 0 && gapCheck && lastTlastCycle >= 0) begin
        checkOutput("bubble_cycles", cyc - lastTlastCycle, 2);
      end
      checkOutput("tdata", m_axis_tdata, mkData(q, expSeq[q], beatIdx));
      checkOutput("tkeep", m_axis_tkeep, mkKeep(isLast));
      checkOutput("tuser", m_axis_tuser, mkUser(q, expSeq[q], 8'(q)));
      checkOutput("tlast", m_axis_tlast, isLast);
      if (isLast) begin
        beatIdx = 0;
        expSeq[q]++;
        pktIdx++;
        lastTlastCycle = cyc;
      end else begin
        beatIdx++;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge axis_aclk);
      fired = s_axis_tvalid & s_axis_tready;
      observeOutput();
    end
  end

  initial begin
    forever begin
      @(posedge axis_aclk);
      cyc++;
      #1;
      applyStimulus();
    end
  end

  task automatic waitPackets(input int n, input int budget);
    int c = 0;
    while (pktIdx < n && c < budget) begin
      @(negedge axis_aclk);
      c++;
    end
    checkOutput("packets_done", pktIdx, n);
    repeat (3) @(negedge axis_aclk);
  endtask

  task automatic startPhase();
    pktIdx = 0;
    beatIdx = 0;
    lastTlastCycle = -1;
  endtask

  initial begin
    int c;
    axis_resetn   = 1'b0;
    m_axis_tready = 1'b1;
    readyToggle   = 1'b0;
    gapCheck      = 1'b0;
    cfg_weights   = 16'h1111;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tuser  = '0;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    srcEn         = 4'hF;
    fired         = '0;
    for (int q = 0; q < NQ; q++) begin
      srcLeft[q] = 2;
      srcLen[q]  = 3;
      srcBeat[q] = 0;
      srcSeq[q]  = 0;
      expSeq[q]  = 0;
    end
    expOrder = {};
    startPhase();

    // Reset held with every queue requesting.
    repeat (3) @(negedge axis_aclk);
    checkOutput("rst_s_tready", s_axis_tready, 0);
    checkOutput("rst_m_tvalid", m_axis_tvalid, 0);
    checkOutput("rst_pkt_count", pkt_count, 0);
    checkOutput("rst_grant_valid", grant_valid, 0);
    checkOutput("rst_grant_id", grant_id, 0);

    // Equal weights, 3-beat packets, round-robin 0..3 twice.
    srcEn[3] = 1'b0;
    repeat (2) @(negedge axis_aclk);
    expOrder = {0, 1, 2, 3, 0, 1, 2, 3};
    startPhase();
    gapCheck = 1'b1;
    axis_resetn = 1'b1;
    @(negedge axis_aclk);
    checkOutput("first_beat_latency", m_axis_tvalid, 1);
    srcEn[3] = 1'b1;
    waitPackets(8, 200);
    checkOutput("pkt_count_rr", pkt_count, 8);

    // Weights q0=3 q1=1 q2=0 q3=1.
    cfg_weights = 16'h1013;
    expOrder = {0, 0, 0, 1, 0, 0, 0, 1};
    startPhase();
    for (int q = 0; q < NQ; q++) srcLen[q] = 2;
    srcLeft[0] = 6;
    srcLeft[1] = 2;
    waitPackets(8, 200);
    checkOutput("pkt_count_wrr", pkt_count, 16);

    // Zero weight on q2 alternates like weight 1; single-beat packets.
    expOrder = {2, 1, 2, 1};
    startPhase();
    for (int q = 0; q < NQ; q++) srcLen[q] = 1;
    srcLeft[1] = 2;
    srcLeft[2] = 2;
    waitPackets(4, 100);
    checkOutput("pkt_count_w0", pkt_count, 20);

    // Backpressure 1010 on a 4-beat q1 packet.
    gapCheck = 1'b0;
    readyToggle = 1'b1;
    expOrder = {1};
    startPhase();
    srcLen[1] = 4;
    srcLeft[1] = 1;
    waitPackets(1, 100);
    readyToggle = 1'b0;
    repeat (2) @(negedge axis_aclk);
    checkOutput("pkt_count_bp", pkt_count, 21);

    // Only q2, weight 2, five 2-beat packets.
    gapCheck = 1'b1;
    cfg_weights = 16'h1213;
    expOrder = {2, 2, 2, 2, 2};
    startPhase();
    srcLen[2] = 2;
    srcLeft[2] = 5;
    waitPackets(5, 200);
    checkOutput("pkt_count_single", pkt_count, 26);

    // Reset during beat 2 of a 4-beat q2 packet.
    gapCheck = 1'b0;
    expOrder = {2};
    startPhase();
    srcLen[2] = 4;
    srcLeft[2] = 1;
    c = 0;
    while (beatIdx < 2 && c < 100) begin
      @(negedge axis_aclk);
      c++;
    end
    checkOutput("mid_packet_beats", beatIdx, 2);
    axis_resetn = 1'b0;
    @(negedge axis_aclk);
    checkOutput("abort_m_tvalid", m_axis_tvalid, 0);
    checkOutput("abort_s_tready", s_axis_tready, 0);
    checkOutput("abort_grant_valid", grant_valid, 0);
    checkOutput("abort_grant_id", grant_id, 0);
    checkOutput("abort_pkt_count", pkt_count, 0);
    for (int q = 0; q < NQ; q++) srcBeat[q] = 0;
    srcLen[1] = 2;
    srcLeft[1] = 1;
    expOrder = {1, 2};
    startPhase();
    gapCheck = 1'b1;
    repeat (2) @(negedge axis_aclk);
    axis_resetn = 1'b1;
    waitPackets(2, 100);
    checkOutput("pkt_count_after_rst", pkt_count, 2);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
